fifo_pop_dispatch: RTL and testbench
====================================

FIFO_POP_DISPATCH -- requirements
Module: fifo_pop_dispatch

Interface
REQ-001 Parameter DATA_W, default 6: word width of each input queue and of the output port.
REQ-002 Parameter CNT_W, default 8: width of each per-queue dispatch counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 grant_valid  input  1  round-robin arbiter presents a selection this cycle.
REQ-006 grant_id  input  2  queue index selected by arbiter (0..3).
REQ-007 fifo_empty  input  4  per-queue empty flags; bit i = queue i empty.
REQ-008 fifo_data  input  4*DATA_W  registered read data; queue i at bits [i*DATA_W +: DATA_W], valid the cycle after its pop.
REQ-009 out_almost_full  input  1  downstream FIFO cannot accept a new transfer.
REQ-010 grant_ack  output  1  one-cycle pulse telling arbiter the grant was taken; arbiter advances pointer.
REQ-011 pop  output  4  one-hot pop strobe to queues.
REQ-012 out_push  output  1  write strobe to downstream FIFO.
REQ-013 out_data  output  DATA_W  word written with out_push.
REQ-014 out_id  output  2  source queue of out_data.
REQ-015 cnt_q  output  4*CNT_W  per-queue dispatched-word counters, queue i at [i*CNT_W +: CNT_W].
REQ-016 drop_cnt  output  CNT_W  count of grants rejected because selected queue was empty.

Function
REQ-017 FSM states IDLE, POP, PUSH; all outputs registered.
REQ-018 IDLE: accept when grant_valid=1, fifo_empty[grant_id]=0, out_almost_full=0; latch grant_id to sel_id, go to POP.
REQ-019 IDLE, grant_valid=1 and fifo_empty[grant_id]=1: no accept, drop_cnt+1, grant_ack=0, stay IDLE.
REQ-020 IDLE, out_almost_full=1: no accept, no drop count, stay IDLE (arbiter holds grant).
REQ-021 POP (cycle N+1 after accept at N): pop[sel_id]=1 and grant_ack=1 for exactly this cycle; go to PUSH.
REQ-022 PUSH (N+2): out_push=1, out_data=fifo_data slice sel_id, out_id=sel_id, cnt_q[sel_id]+1; go to IDLE.
REQ-023 Earliest next accept is in IDLE at N+3; peak throughput one word per 3 cycles.
REQ-024 out_almost_full rising after accept does not abort the transfer; the in-flight word completes.
REQ-025 grant_valid/grant_id changes during POP/PUSH are ignored.
REQ-026 Counters wrap modulo 2^CNT_W (255 -> 0 at default), no saturation.
REQ-027 At most one pop bit and one counter update per cycle; pop never asserted for an empty-at-accept queue.

Reset
REQ-028 reset=0: state IDLE; pop=0, grant_ack=0, out_push=0, out_data=0, out_id=0, all cnt_q=0, drop_cnt=0, sel_id=0.
REQ-029 Reset during POP or PUSH abandons the transfer; no push follows deassertion; a popped word may be lost (accepted).
REQ-030 First accept possible on the first rising edge with reset=1.

Structure
REQ-031 Shared package holds state encodings (IDLE=0, POP=1, PUSH=2), N_Q=4 and default DATA_W/CNT_W.
REQ-032 One sub-module, dispatch_counter (CNT_W wrap counter with increment enable), instantiated 5 times (4 queues + drop).
REQ-033 Data-slice mux, FSM and pop decode live in fifo_pop_dispatch.

Verification
REQ-034 Reset then grant_valid=1, grant_id=2, fifo_empty=0000, fifo_data q2=6'b101101 -> pop=0100 and grant_ack at N+1, out_push, out_data=101101, out_id=2 at N+2, cnt_q[2]=1.
REQ-035 grant_id=1, fifo_empty=0010 for 3 cycles -> no pop, no push, drop_cnt=3.
REQ-036 out_almost_full=1 with valid grant for 4 cycles then 0 -> no pop while high; accept next cycle; drop_cnt unchanged.
REQ-037 Back-to-back grants 0,1,2,3 held valid -> pushes 3 cycles apart, out_id 0,1,2,3, each cnt_q=1.
REQ-038 256 pushes from queue 3 -> cnt_q[3] wraps to 0; other counters 0.
REQ-039 reset=0 asserted asynchronously mid-POP -> pop, grant_ack immediately 0; no out_push after reset releases; all counters 0.

Source files
------------

// File: rtl/fifo_pop_dispatch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_pop_dispatch_pkg                              |
// | Description : Shared state encoding, queue count and default     |
// |               widths for the FIFO pop dispatcher.                |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package fifo_pop_dispatch_pkg;

  localparam int N_Q        = 4;
  localparam int DEF_DATA_W = 6;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  // One-hot select of a queue index
  function automatic logic [N_Q-1:0] id_onehot(input logic [1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_pop_dispatch_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dispatch_counter                                   |
// | Description : Free-running wrap counter with increment enable.   |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module dispatch_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count enabled events; wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_pop_dispatch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fifo_pop_dispatch                                  |
// | Description : Takes a round-robin grant, pops the selected input |
// |               queue and forwards the word to a downstream FIFO,  |
// |               keeping per-queue dispatch and drop counters.      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module fifo_pop_dispatch
  import fifo_pop_dispatch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  grant_valid,
  input  logic [1:0]            grant_id,
  input  logic [N_Q-1:0]        fifo_empty,
  input  logic [N_Q*DATA_W-1:0] fifo_data,
  input  logic                  out_almost_full,
  output logic                  grant_ack,
  output logic [N_Q-1:0]        pop,
  output logic                  out_push,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_id,
  output logic [N_Q*CNT_W-1:0]  cnt_q,
  output logic [CNT_W-1:0]      drop_cnt
);

  state_t     r_state;
  logic [1:0] r_sel_id;
  logic       w_accept;
  logic       w_drop;

  // Back-pressure has priority: while downstream is full the arbiter holds
  // its grant, so an empty selection is not counted as a drop.
  assign w_accept = (r_state == ST_IDLE) && grant_valid && !out_almost_full
                    && !fifo_empty[grant_id];
  assign w_drop   = (r_state == ST_IDLE) && grant_valid && !out_almost_full
                    && fifo_empty[grant_id];

  // Dispatch FSM: IDLE -> POP (pop + ack) -> PUSH (write downstream) -> IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_sel_id  <= 2'd0;
      pop       <= '0;
      grant_ack <= 1'b0;
      out_push  <= 1'b0;
      out_id    <= 2'd0;
    end else begin
      pop       <= '0;
      grant_ack <= 1'b0;
      out_push  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel_id  <= grant_id;
            pop       <= id_onehot(grant_id);
            grant_ack <= 1'b1;
            r_state   <= ST_POP;
          end
        end
        ST_POP: begin
          out_push <= 1'b1;
          out_id   <= r_sel_id;
          r_state  <= ST_PUSH;
        end
        ST_PUSH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The queue's read register only holds the popped word during PUSH, so
  // the data path is a state-gated mux of that registered source rather
  // than a second capture stage that would push a cycle later.
  always_comb begin
    out_data = '0;
    if (r_state == ST_PUSH) begin
      out_data = fifo_data[int'(r_sel_id)*DATA_W +: DATA_W];
    end
  end

  // Per-queue dispatched-word counters, bumped as the word leaves in PUSH
  for (genvar i = 0; i < N_Q; i++) begin : g_q_cnt
    logic w_inc;
    assign w_inc = (r_state == ST_PUSH) && (r_sel_id == 2'(i));
    dispatch_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_inc),
      .cnt   (cnt_q[i*CNT_W +: CNT_W])
    );
  end

  // Grants rejected because the selected queue was empty
  dispatch_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_drop),
    .cnt   (drop_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_dispatch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_fifo_pop_dispatch                               |
// | Description : Directed self-checking bench for fifo_pop_dispatch |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_fifo_pop_dispatch;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 8;

  logic                clk;
  logic                reset;
  logic                grant_valid;
  logic [1:0]          grant_id;
  logic [3:0]          fifo_empty;
  logic [4*DATA_W-1:0] fifo_data;
  logic                out_almost_full;
  logic                grant_ack;
  logic [3:0]          pop;
  logic                out_push;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_id;
  logic [4*CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]    drop_cnt;

  int checks   = 0;
  int failures = 0;

  fifo_pop_dispatch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .grant_valid     (grant_valid),
    .grant_id        (grant_id),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .out_almost_full (out_almost_full),
    .grant_ack       (grant_ack),
    .pop             (pop),
    .out_push        (out_push),
    .out_data        (out_data),
    .out_id          (out_id),
    .cnt_q           (cnt_q),
    .drop_cnt        (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int q);
    cnt_of = 32'(cnt_q[q*CNT_W +: CNT_W]);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pop"},  32'(pop), 32'h0);
    chk({tag, "_ack"},  32'(grant_ack), 32'h0);
    chk({tag, "_push"}, 32'(out_push), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int acks;
  int pushes;
  logic last_push;

  initial begin
    reset           = 1'b0;
    grant_valid     = 1'b0;
    grant_id        = 2'd0;
    fifo_empty      = 4'hF;
    fifo_data       = '0;
    out_almost_full = 1'b0;

    // ---- Reset state
    @(negedge clk);
    @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_id",   32'(out_id),   32'h0);
    chk("rst_cnt_q",    cnt_q,         32'h0);
    chk("rst_drop",     32'(drop_cnt), 32'h0);
    reset = 1'b1;

    // ---- Single transfer from queue 2; read data appears after the pop
    grant_valid = 1'b1;
    grant_id    = 2'd2;
    fifo_empty  = 4'b0000;
    fifo_data   = {6'h3F, 6'h3F, 6'h3F, 6'h3F};
    @(negedge clk);                        // N+1
    chk("t1_pop",  32'(pop), 32'h4);
    chk("t1_ack",  32'(grant_ack), 32'h1);
    chk("t1_push_early", 32'(out_push), 32'h0);
    grant_valid = 1'b0;
    @(posedge clk);
    #1 fifo_data = {6'h3F, 6'b101101, 6'h3F, 6'h3F};
    @(negedge clk);                        // N+2
    chk("t1_push", 32'(out_push), 32'h1);
    chk("t1_data", 32'(out_data), 32'h2D);
    chk("t1_id",   32'(out_id),   32'h2);
    chk("t1_pop_off", 32'(pop), 32'h0);
    @(negedge clk);                        // N+3
    chk("t1_push_off", 32'(out_push), 32'h0);
    chk("t1_cnt2", cnt_of(2), 32'd1);
    chk("t1_cnt0", cnt_of(0), 32'd0);

    // ---- Three grants at an empty queue are dropped
    grant_valid = 1'b1;
    grant_id    = 2'd1;
    fifo_empty  = 4'b0010;
    @(negedge clk);
    chk_idle_outputs("t2_c1");
    chk("t2_drop1", 32'(drop_cnt), 32'd1);
    @(negedge clk);
    chk_idle_outputs("t2_c2");
    @(negedge clk);
    chk_idle_outputs("t2_c3");
    chk("t2_drop3", 32'(drop_cnt), 32'd3);
    grant_valid = 1'b0;
    @(negedge clk);
    chk("t2_drop_hold", 32'(drop_cnt), 32'd3);
    chk("t2_cnt1", cnt_of(1), 32'd0);

    // ---- Back-pressure holds the grant, then transfer proceeds
    fifo_empty      = 4'b0000;
    fifo_data       = {6'h3C, 6'h2D, 6'h22, 6'h11};
    grant_valid     = 1'b1;
    grant_id        = 2'd0;
    out_almost_full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle_outputs($sformatf("t3_hold%0d", c));
    end
    out_almost_full = 1'b0;
    @(negedge clk);
    chk("t3_pop",  32'(pop), 32'h1);
    chk("t3_ack",  32'(grant_ack), 32'h1);
    chk("t3_drop", 32'(drop_cnt), 32'd3);
    grant_valid     = 1'b0;
    out_almost_full = 1'b1;                // rises after accept: must not abort
    @(negedge clk);
    chk("t3_push", 32'(out_push), 32'h1);
    chk("t3_data", 32'(out_data), 32'h11);
    chk("t3_id",   32'(out_id),   32'h0);
    @(negedge clk);
    chk("t3_cnt0", cnt_of(0), 32'd1);
    out_almost_full = 1'b0;

    // ---- Back-to-back grants 0..3, pushes every third cycle
    do_reset();
    grant_valid = 1'b1;
    grant_id    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);                      // POP cycle
      chk($sformatf("t4_pop%0d", k), 32'(pop), 32'(4'b0001 << k));
      chk($sformatf("t4_ack%0d", k), 32'(grant_ack), 32'h1);
      if (k == 3) grant_valid = 1'b0;
      else        grant_id    = 2'(k + 1);
      @(negedge clk);                      // PUSH cycle
      chk($sformatf("t4_push%0d", k), 32'(out_push), 32'h1);
      chk($sformatf("t4_id%0d", k),   32'(out_id),   32'(k));
      chk($sformatf("t4_data%0d", k), 32'(out_data), 32'(fifo_data[k*DATA_W +: DATA_W]));
      @(negedge clk);                      // IDLE cycle
      chk_idle_outputs($sformatf("t4_idle%0d", k));
    end
    for (int q = 0; q < 4; q++) begin
      chk($sformatf("t4_cnt%0d", q), cnt_of(q), 32'd1);
    end
    chk("t4_drop", 32'(drop_cnt), 32'd0);

    // ---- 256 pushes from queue 3 wrap its counter
    do_reset();
    grant_id    = 2'd3;
    grant_valid = 1'b1;
    acks        = 0;
    pushes      = 0;
    last_push   = 1'b0;
    for (int c = 0; c < 900 && pushes < 256; c++) begin
      @(negedge clk);
      if (last_push && pushes == 255) chk("t5_cnt255", cnt_of(3), 32'd255);
      last_push = out_push;
      if (out_push) pushes++;
      if (grant_ack) begin
        acks++;
        if (acks == 256) grant_valid = 1'b0;
      end
    end
    chk("t5_pushes", 32'(pushes), 32'd256);
    @(negedge clk);
    chk("t5_cnt3_wrap", cnt_of(3), 32'd0);
    chk("t5_cnt_others", {8'h0, cnt_q[23:0]}, 32'h0);
    chk("t5_push_off", 32'(out_push), 32'h0);

    // ---- Async reset in the middle of POP abandons the transfer
    grant_valid = 1'b1;
    grant_id    = 2'd1;
    fifo_empty  = 4'b0010;                 // one drop so counters are nonzero
    @(negedge clk);
    chk("t6_pre_drop", 32'(drop_cnt), 32'd1);
    fifo_empty = 4'b0000;
    @(negedge clk);
    chk("t6_pop", 32'(pop), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("t6_pop_async", 32'(pop), 32'h0);
    chk("t6_ack_async", 32'(grant_ack), 32'h0);
    grant_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t6_nopush%0d", c), 32'(out_push), 32'h0);
    end
    chk("t6_cnt_q", cnt_q, 32'h0);
    chk("t6_drop",  32'(drop_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
